fp_addsub_seq: RTL and testbench

Multi-cycle sequencer for single-precision (IEEE-754 layout) add/subtract. It accepts an operand pair over a valid/ready handshake, aligns exponents one bit per cycle, and performs one 25-bit magnitude add or subtract. It then normalizes iteratively, one shift per cycle, with exponent bookkeeping and exception flags, and returns the packed result over a second handshake. It is the controller that time-shares a single shifter/adder datapath among the floating-point ALU's add and sub operations.

---
 rtl/fp_addsub_seq_if.sv | 24 ++
 rtl/fp_addsub_seq.sv | 154 +++++++++++++++
 tb/tb_fp_addsub_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// Handshake and operand/result bundle for the sequential single-precision add/sub unit.
interface fp_addsub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        exc_input;
  logic        exc_overflow;
  logic        exc_underflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, exc_input, exc_overflow, exc_underflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, exc_input, exc_overflow, exc_underflow
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle single-precision add/subtract: bit-serial exponent alignment,
// one 25-bit magnitude add/sub, then iterative one-shift-per-cycle normalization.
module fp_addsub_seq (
  input  logic            clk,
  input  logic            rst,
  fp_addsub_seq_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  r_state;
  logic        r_sign_x;
  logic        r_sign_y;
  logic [7:0]  r_exp;
  logic [23:0] r_mant_x;
  logic [23:0] r_mant_y;
  logic [4:0]  r_diff;
  logic [24:0] r_sum;
  logic [31:0] r_result;
  logic        r_out_valid;
  logic        r_exc_input;
  logic        r_exc_overflow;
  logic        r_exc_underflow;

  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [23:0] w_mant_a;
  logic [23:0] w_mant_b;
  logic        w_sign_b;
  logic        w_a_is_x;
  logic        w_bad_exp;
  logic [7:0]  w_diff_raw;
  logic [4:0]  w_diff;
  logic [24:0] w_round;

  always_comb begin
    w_exp_a   = bus.a[30:23];
    w_exp_b   = bus.b[30:23];
    w_mant_a  = {1'b1, bus.a[22:0]};
    w_mant_b  = {1'b1, bus.b[22:0]};
    w_sign_b  = bus.b[31] ^ bus.op;
    w_a_is_x  = (w_exp_a > w_exp_b) || ((w_exp_a == w_exp_b) && (w_mant_a >= w_mant_b));
    w_bad_exp = (w_exp_a == 8'h00) || (w_exp_a == 8'hFF) ||
                (w_exp_b == 8'h00) || (w_exp_b == 8'hFF);
    w_diff_raw = w_a_is_x ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
    // Beyond 25 shifts the smaller mantissa is already fully flushed to zero.
    w_diff     = (w_diff_raw > 8'd25) ? 5'd25 : w_diff_raw[4:0];
    w_round    = {1'b0, r_sum[24:1]} + {24'b0, r_sum[0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_sign_x        <= 1'b0;
      r_sign_y        <= 1'b0;
      r_exp           <= '0;
      r_mant_x        <= '0;
      r_mant_y        <= '0;
      r_diff          <= '0;
      r_sum           <= '0;
      r_result        <= '0;
      r_out_valid     <= 1'b0;
      r_exc_input     <= 1'b0;
      r_exc_overflow  <= 1'b0;
      r_exc_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sign_x <= w_a_is_x ? bus.a[31] : w_sign_b;
            r_sign_y <= w_a_is_x ? w_sign_b  : bus.a[31];
            r_exp    <= w_a_is_x ? w_exp_a   : w_exp_b;
            r_mant_x <= w_a_is_x ? w_mant_a  : w_mant_b;
            r_mant_y <= w_a_is_x ? w_mant_b  : w_mant_a;
            r_diff   <= w_diff;
            if (w_bad_exp) begin
              r_exc_input <= 1'b1;
              r_result    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state     <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (r_diff != 5'd0) begin
            r_mant_y <= r_mant_y >> 1;
            r_diff   <= r_diff - 5'd1;
          end else begin
            r_state  <= ADD;
          end
        end
        ADD: begin
          r_sum   <= (r_sign_x == r_sign_y) ? ({1'b0, r_mant_x} + {1'b0, r_mant_y})
                                            : ({1'b0, r_mant_x} - {1'b0, r_mant_y});
          r_state <= NORM;
        end
        NORM: begin
          if (r_sum == 25'd0) begin
            r_result    <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_sum[24]) begin
            if (r_exp == 8'd254) begin
              r_exc_overflow <= 1'b1;
              r_result       <= '0;
              r_out_valid    <= 1'b1;
              r_state        <= DONE;
            end else begin
              // A carry out of the rounding increment re-enters this branch next cycle.
              r_sum <= w_round;
              r_exp <= r_exp + 8'd1;
            end
          end else if (r_sum[23]) begin
            r_result    <= {r_sign_x, r_exp, r_sum[22:0]};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_exp == 8'd1) begin
            r_exc_underflow <= 1'b1;
            r_result        <= '0;
            r_out_valid     <= 1'b1;
            r_state         <= DONE;
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid     <= 1'b0;
            r_exc_input     <= 1'b0;
            r_exc_overflow  <= 1'b0;
            r_exc_underflow <= 1'b0;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (r_state == IDLE) && !rst;
  assign bus.out_valid     = r_out_valid;
  assign bus.result        = r_result;
  assign bus.exc_input     = r_exc_input;
  assign bus.exc_overflow  = r_exc_overflow;
  assign bus.exc_underflow = r_exc_underflow;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: expected result, flags and latency are queued at accept
// and compared by a monitor when out_valid rises; scenario tasks check handshake behaviour.
module tb_fp_addsub_seq;

  logic clk = 1'b0;
  logic rst;

  fp_addsub_seq_if bus();

  fp_addsub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;   // {overflow, underflow, input}
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: one comparison set per out_valid rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_result got=%h required=none", bus.result);
      end else begin
        m_e = sb.pop_front();
        total++;
        if (bus.result !== m_e.res)
          $display("FAIL %s_result got=%h required=%h", m_e.name, bus.result, m_e.res);
        else passed++;
        total++;
        if ({bus.exc_overflow, bus.exc_underflow, bus.exc_input} !== m_e.fl)
          $display("FAIL %s_flags got=%b required=%b", m_e.name,
                   {bus.exc_overflow, bus.exc_underflow, bus.exc_input}, m_e.fl);
        else passed++;
        total++;
        if ((cyc - m_e.acc) != m_e.lat)
          $display("FAIL %s_latency got=%0d required=%0d", m_e.name, cyc - m_e.acc, m_e.lat);
        else passed++;
      end
    end
    prev_ov = bus.out_valid;
  end

  function automatic void model(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                                output logic [31:0] res, output logic [2:0] fl, output int lat);
    int ex, ey, mx, my, d, s, e, sh, t;
    logic sx, sy, st;
    ex = int'(va[30:23]); ey = int'(vb[30:23]);
    mx = 32'h800000 | int'(va[22:0]); my = 32'h800000 | int'(vb[22:0]);
    sx = va[31]; sy = vb[31] ^ vop;
    res = '0; fl = 3'b000; sh = 0;
    if (ex == 0 || ex == 255 || ey == 0 || ey == 255) begin
      fl = 3'b001; lat = 1; return;
    end
    if (ey > ex || (ey == ex && my > mx)) begin
      t = ex; ex = ey; ey = t;
      t = mx; mx = my; my = t;
      st = sx; sx = sy; sy = st;
    end
    d = ex - ey;
    if (d > 25) d = 25;
    my = (d >= 24) ? 0 : (my >> d);
    s = (sx == sy) ? (mx + my) : (mx - my);
    e = ex;
    for (int k = 0; k < 100; k++) begin
      if (s == 0) break;
      else if (s >= 32'h1000000) begin
        if (e == 254) begin fl = 3'b100; break; end
        s = (s >> 1) + (s & 1); e++; sh++;
      end else if (s >= 32'h800000) begin
        res = {sx, e[7:0], s[22:0]}; break;
      end else if (e == 1) begin
        fl = 3'b010; break;
      end else begin
        s = s << 1; e--; sh++;
      end
    end
    lat = d + sh + 4;
  endfunction

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                      input logic [31:0] eres, input logic [2:0] efl, input int elat,
                      input string nm, input bit keep);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL %s_accept_timeout got=in_ready_low required=in_ready_high", nm);
    end
    bus.a = va; bus.b = vb; bus.op = vop; bus.in_valid = 1'b1;
    e.res = eres; e.fl = efl; e.lat = elat; e.acc = cyc; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    if (keep) begin
      bus.a = ~va; bus.b = 32'h3F800000; bus.op = ~vop;
    end else bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #2; n++; end
    if (!bus.out_valid) begin
      total++;
      $display("FAIL %s_timeout got=no_out_valid required=out_valid", nm);
    end
  endtask

  task automatic release_out();
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #2; bus.out_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                     input logic [31:0] eres, input logic [2:0] efl, input int elat, input string nm);
    send(va, vb, vop, eres, efl, elat, nm, 1'b0);
    wait_out(nm);
    release_out();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.exc_input, bus.exc_overflow, bus.exc_underflow} !== 5'b0 ||
        bus.result !== 32'h0)
      $display("FAIL reset_outputs got=ov%b ir%b fl%b%b%b res=%h required=all_zero", bus.out_valid,
               bus.in_ready, bus.exc_overflow, bus.exc_underflow, bus.exc_input, bus.result);
    else passed++;
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b required=1", bus.in_ready);
    else passed++;
  endtask

  task automatic test_add();
    run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5, "add_1p1");
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL handshake_release got=ov%b ir%b required=ov0 ir1", bus.out_valid, bus.in_ready);
    else passed++;
    run(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 6, "add_3p1");
  endtask

  task automatic test_sub();
    run(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000, 7, "sub_1m075");
    run(32'h3F400000, 32'h3F800000, 1'b1, 32'hBE800000, 3'b000, 7, "sub_075m1");
    run(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000, 4, "sub_cancel");
    run(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000, 4, "add_opposite");
  endtask

  task automatic test_round();
    run(32'h3FFFFFFF, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 5, "round_up");
    run(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFF, 3'b000, 5, "round_even");
  endtask

  task automatic test_align();
    run(32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 3'b000, 27, "align_23");
    run(32'h3F800000, 32'h4F000000, 1'b0, 32'h4F000000, 3'b000, 29, "align_clamp");
  endtask

  task automatic test_exceptions();
    logic [31:0] snap;
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h0, 3'b100, 4, "overflow");
    run(32'h00C00000, 32'h00800000, 1'b1, 32'h0, 3'b010, 4, "underflow");
    run(32'h3F800000, 32'h7F800000, 1'b0, 32'h0, 3'b001, 1, "inf_input");
    send(32'h00000000, 32'h3F800000, 1'b0, 32'h0, 3'b001, 1, "zero_input", 1'b0);
    wait_out("zero_input");
    snap = bus.result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== snap || bus.result !== 32'h0 ||
          bus.in_ready !== 1'b0 || bus.exc_input !== 1'b1)
        $display("FAIL hold_%0d got=ov%b ir%b ei%b res=%h required=ov1 ir0 ei1 res=00000000",
                 i, bus.out_valid, bus.in_ready, bus.exc_input, bus.result);
      else passed++;
    end
    release_out();
    total++;
    if ({bus.out_valid, bus.exc_input} !== 2'b00)
      $display("FAIL hold_release got=ov%b ei%b required=ov0 ei0", bus.out_valid, bus.exc_input);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int busy_bad = 0;
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 6, "busy_ignore", 1'b1);
    for (int n = 0; n < 100 && !bus.out_valid; n++) begin
      if (bus.in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #2;
    end
    @(negedge clk); bus.in_valid = 1'b0;
    total++;
    if (busy_bad != 0 || bus.out_valid !== 1'b1)
      $display("FAIL busy_ready got=%0d_ready_cycles ov%b required=0 ov1", busy_bad, bus.out_valid);
    else passed++;
    release_out();
  endtask

  task automatic test_reset_mid();
    send(32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 3'b000, 27, "aborted", 1'b0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    sb.delete();
    total++;
    if ({bus.out_valid, bus.in_ready, bus.exc_input, bus.exc_overflow, bus.exc_underflow} !== 5'b0 ||
        bus.result !== 32'h0)
      $display("FAIL midreset_outputs got=ov%b ir%b res=%h required=ov0 ir0 res=00000000",
               bus.out_valid, bus.in_ready, bus.result);
    else passed++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL midreset_release got=ir%b ov%b required=ir1 ov0", bus.in_ready, bus.out_valid);
    else passed++;
    run(32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 3'b000, 27, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] va, vb, er;
    logic [2:0]  ef;
    logic        vop;
    int          el, ea, eb;
    for (int i = 0; i < 16; i++) begin
      ea  = $urandom_range(140, 100);
      eb  = ea - 3 + $urandom_range(6, 0);
      va  = {1'($urandom_range(1, 0)), 8'(ea), 23'($urandom)};
      vb  = {1'($urandom_range(1, 0)), 8'(eb), 23'($urandom)};
      vop = 1'($urandom_range(1, 0));
      model(va, vb, vop, er, ef, el);
      run(va, vb, vop, er, ef, el, "random");
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_round();
    test_align();
    test_exceptions();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
